insn_encode: RTL and testbench

Instruction encoder for the RV32I datapath, the inverse of the decode stage. It accepts decoded instruction fields over a valid/ready handshake, assembles the 32-bit instruction word according to the opcode's format, and buffers results in a small FIFO. Used by the self-check and replay path to regenerate instruction words from field bundles, and as a reference model for decode.

---
 rtl/insn_encode_pkg.sv | 51 +++++
 rtl/insn_encode_fifo.sv | 60 ++++++
 rtl/insn_encode.sv | 142 ++++++++++++++
 tb/tb_insn_encode.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_encode_pkg.sv
// Opcodes, instruction formats and the buffered entry type shared by the RV32I encoder and its FIFO.
// The entry is fixed at 32-bit insn/pc, so the top's DWIDTH/AWIDTH must stay at 32.
package insn_encode_pkg;

   localparam int ENC_DWIDTH = 32;
   localparam int ENC_AWIDTH = 32;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ENC_DWIDTH-1:0] INSN_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_e;

   typedef struct packed {
      logic [ENC_DWIDTH-1:0] insn;
      logic [ENC_AWIDTH-1:0] pc;
      logic                  err;
   } enc_entry_t;

   function automatic fmt_e fmt_of(input logic [6:0] opcode);
      fmt_e f;
      case (opcode)
         OP_REG:                              f = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
         OP_STORE:                            f = FMT_S;
         OP_BRANCH:                           f = FMT_B;
         OP_LUI, OP_AUIPC:                    f = FMT_U;
         OP_JAL:                              f = FMT_J;
         default:                             f = FMT_BAD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/insn_encode_fifo.sv
// First-word fall-through FIFO of encoded entries; head is visible the cycle after a push.
// The writer guarantees space, so push is unconditional; pop is valid && rdy on the head.
module insn_encode_fifo
   import insn_encode_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push_vld,
   input  enc_entry_t    i_push_dat,
   input  logic          i_pop_rdy,
   output logic          o_head_vld,
   output enc_entry_t    o_head_dat,
   output logic [CW-1:0] o_count
);

   localparam int PW = $clog2(FIFO_DEPTH);

   enc_entry_t    r_mem [FIFO_DEPTH];
   enc_entry_t    r_last;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop;

   assign o_head_vld = (r_count != '0);
   assign w_pop      = o_head_vld && i_pop_rdy;
   assign o_count    = r_count;
   // When drained, the outputs keep showing the last entry handed to the consumer.
   assign o_head_dat = o_head_vld ? r_mem[r_rd_ptr] : r_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push_vld) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_last   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push_vld, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/insn_encode.sv
// RV32I field-bundle encoder; define INSN_ENCODE_IMM_CHECK_EN to flag out-of-range immediates.
// Accept -> stage-1 register -> FWFT FIFO (valid_o one edge after accept); ready_o drops when FIFO + stage fill.
module insn_encode
   import insn_encode_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [AWIDTH-1:0] pc_i,
   input  logic [6:0]        opcode_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [4:0]        shamt_i,
   input  logic [DWIDTH-1:0] imm_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] insn_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic              err_o,
   output logic [15:0]       err_cnt_o
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

   fmt_e              w_fmt;
   logic              w_is_shift;
   logic [DWIDTH-1:0] w_insn;
   logic              w_bad_imm;
   logic              w_err;
   logic              w_accept;
   logic [CW-1:0]     w_count;
   logic [CW:0]       w_occupancy;
   logic              w_head_vld;
   enc_entry_t        w_head;

   logic              r_s1_vld;
   enc_entry_t        r_s1_entry;
   logic [15:0]       r_err_cnt;

   assign w_fmt      = fmt_of(opcode_i);
   assign w_is_shift = (opcode_i == OP_IMM) && (funct3_i[1:0] == 2'b01);

   always_comb begin
      w_insn = INSN_NOP;
      case (w_fmt)
         FMT_R: w_insn = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: begin
            if (w_is_shift) begin
               w_insn = {funct7_i, shamt_i, rs1_i, funct3_i, rd_i, opcode_i};
            end else begin
               w_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
         end
         FMT_S: w_insn = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: w_insn = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: w_insn = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: w_insn = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         default: w_insn = INSN_NOP;
      endcase
   end

`ifdef INSN_ENCODE_IMM_CHECK_EN
   logic signed [DWIDTH-1:0] w_imm_s;
   assign w_imm_s = $signed(imm_i);

   // Failing beats are still encoded (truncated); only the err flag reflects the check.
   always_comb begin
      w_bad_imm = 1'b0;
      case (w_fmt)
         FMT_I: begin
            if (w_is_shift) begin
               w_bad_imm = !((funct7_i == 7'h00) ||
                             ((funct7_i == 7'h20) && (funct3_i == 3'b101)));
            end else begin
               w_bad_imm = (w_imm_s < -2048) || (w_imm_s > 2047);
            end
         end
         FMT_S: w_bad_imm = (w_imm_s < -2048) || (w_imm_s > 2047);
         FMT_B: w_bad_imm = (w_imm_s < -4096) || (w_imm_s > 4094) || imm_i[0];
         FMT_J: w_bad_imm = (w_imm_s < -(2 ** 20)) || (w_imm_s > (2 ** 20) - 2) || imm_i[0];
         FMT_U: w_bad_imm = (imm_i[11:0] != 12'h000);
         default: w_bad_imm = 1'b0;
      endcase
   end
`else
   assign w_bad_imm = 1'b0;
`endif

   assign w_err       = (w_fmt == FMT_BAD) || w_bad_imm;
   assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_s1_vld};
   assign ready_o     = (w_occupancy < DEPTH_V);
   assign w_accept    = valid_i && ready_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld   <= 1'b0;
         r_s1_entry <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_entry.insn <= w_insn;
            r_s1_entry.pc   <= pc_i;
            r_s1_entry.err  <= w_err;
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
      end
   end

   insn_encode_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push_vld (r_s1_vld),
      .i_push_dat (r_s1_entry),
      .i_pop_rdy  (ready_i),
      .o_head_vld (w_head_vld),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

   assign valid_o   = w_head_vld;
   assign insn_o    = w_head.insn;
   assign pc_o      = w_head.pc;
   assign err_o     = w_head.err;
   assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_insn_encode.sv
// Bench for insn_encode: queue-based scoreboard of accepted bundles, checked every cycle at negedge.
module tb_insn_encode;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic          ready_o;
   logic [AW-1:0] pc_i;
   logic [6:0]    opcode_i;
   logic [4:0]    rd_i, rs1_i, rs2_i;
   logic [2:0]    funct3_i;
   logic [6:0]    funct7_i;
   logic [4:0]    shamt_i;
   logic [DW-1:0] imm_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] insn_o;
   logic [AW-1:0] pc_o;
   logic          err_o;
   logic [15:0]   err_cnt_o;

   insn_encode #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
      .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i), .imm_i(imm_i),
      .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .pc_o(pc_o),
      .err_o(err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   exp_t        q[$];
   exp_t        last_pop;
   bit          acc_last;
   int unsigned m_errcnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
   int         bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                            1048574, 1048576, -1048576, -1048578, 3, -1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // n bits of v starting at bit lo, placed at instruction bit pos
   function automatic longint unsigned at(input longint unsigned v, input int lo, input int n,
                                          input int pos);
      return ((v >> lo) & ((64'd1 << n) - 64'd1)) << pos;
   endfunction

   function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
         input logic [6:0] f7, input logic [4:0] sh, input logic [31:0] imm);
      longint unsigned u     = imm;
      longint          s     = $signed(imm);
      longint unsigned regs  = at(rd, 0, 5, 7) | at(f3, 0, 3, 12) | at(rs1, 0, 5, 15);
      longint unsigned w;
      bit              bad   = 1'b0;
      bit              shift = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
      case (op)
         7'h33: w = at(f7, 0, 7, 25) | at(rs2, 0, 5, 20) | regs | op;
         7'h13, 7'h03, 7'h67, 7'h73: begin
            if (shift) w = at(f7, 0, 7, 25) | at(sh, 0, 5, 20) | regs | op;
            else       w = at(u, 0, 12, 20) | regs | op;
         end
         7'h23: w = at(u, 5, 7, 25) | at(rs2, 0, 5, 20) | at(rs1, 0, 5, 15) | at(f3, 0, 3, 12)
                    | at(u, 0, 5, 7) | op;
         7'h63: w = at(u, 12, 1, 31) | at(u, 5, 6, 25) | at(rs2, 0, 5, 20) | at(rs1, 0, 5, 15)
                    | at(f3, 0, 3, 12) | at(u, 1, 4, 8) | at(u, 11, 1, 7) | op;
         7'h37, 7'h17: w = at(u, 12, 20, 12) | at(rd, 0, 5, 7) | op;
         7'h6F: w = at(u, 20, 1, 31) | at(u, 1, 10, 21) | at(u, 11, 1, 20) | at(u, 12, 8, 12)
                    | at(rd, 0, 5, 7) | op;
         default: begin
            w   = 64'h13;
            bad = 1'b1;
         end
      endcase
`ifdef INSN_ENCODE_IMM_CHECK_EN
      case (op)
         7'h13, 7'h03, 7'h67, 7'h73: begin
            if (shift) bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
            else       bad = (s < -2048) || (s > 2047);
         end
         7'h23:        bad = (s < -2048) || (s > 2047);
         7'h63:        bad = (s < -4096) || (s > 4094) || u[0];
         7'h6F:        bad = (s < -1048576) || (s > 1048574) || u[0];
         7'h37, 7'h17: bad = (u & 64'hFFF) != 0;
         default: ;
      endcase
`else
      if (s == 0) bad = bad;
`endif
      return {bad, w[31:0]};
   endfunction

   // Single compare process: check DUT against the model, then advance the model to the next edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [32:0] r;
      bit          exp_vld, exp_rdy, acc, pop;
      if (rst) begin
         q.delete();
         acc_last = 1'b0;
         m_errcnt = 0;
         last_pop = '0;
         chk("rst ready_o", ready_o, 1);
         chk("rst valid_o", valid_o, 0);
         chk("rst insn_o", insn_o, 0);
         chk("rst pc_o", pc_o, 0);
         chk("rst err_o", err_o, 0);
         chk("rst err_cnt_o", err_cnt_o, 0);
      end else begin
         exp_vld = (q.size() - int'(acc_last)) > 0;
         exp_rdy = q.size() < DEPTH;
         chk("ready_o", ready_o, exp_rdy);
         chk("valid_o", valid_o, exp_vld);
         chk("err_cnt_o", err_cnt_o, m_errcnt);
         e = exp_vld ? q[0] : last_pop;
         chk(exp_vld ? "head insn_o" : "hold insn_o", insn_o, e.insn);
         chk(exp_vld ? "head pc_o" : "hold pc_o", pc_o, e.pc);
         chk(exp_vld ? "head err_o" : "hold err_o", err_o, e.err);
         pop = exp_vld && ready_i;
         acc = exp_rdy && valid_i;
         if (pop) last_pop = q.pop_front();
         if (acc) begin
            r = model_enc(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, shamt_i, imm_i);
            q.push_back('{insn: r[31:0], pc: pc_i, err: r[32]});
            if (r[32] && m_errcnt < 32'hFFFF) m_errcnt++;
         end
         acc_last = acc;
      end
   end

   task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
         input logic [4:0] sh, input logic [31:0] imm, input logic [31:0] pc);
      opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3;
      funct7_i = f7; shamt_i = sh; imm_i = imm; pc_i = pc;
   endtask

   task automatic rand_fields();
      logic [31:0] imm;
      logic [6:0]  op;
      logic [6:0]  f7;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 4))
         0:       imm = $urandom;
         1:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
         2:       imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
         3:       imm = 32'(bnd[$urandom_range(0, 13)]);
         default: imm = $urandom & 32'hFFFF_F000;
      endcase
      case ($urandom_range(0, 2))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      set_fields(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), f7,
                 5'($urandom), imm, $urandom);
   endtask

   // Starts at posedge+1 with an empty pipeline and ready_i = 1; ends the same way.
   task automatic one_shot(input string name, input logic [6:0] op, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
         input logic [31:0] imm, input logic [31:0] exp_insn, input logic exp_err);
      logic [32:0] r;
      set_fields(op, rd, rs1, rs2, f3, 7'h00, 5'd0, imm, 32'h1000_0000 + imm);
      r = model_enc(op, rd, rs1, rs2, f3, 7'h00, 5'd0, imm);
      chk({name, " model"}, r, {exp_err, exp_insn});
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk({name, " valid_o after 1 edge"}, valid_o, 0);
      @(negedge clk);
      chk({name, " valid_o after 2 edges"}, valid_o, 1);
      chk({name, " insn_o"}, insn_o, exp_insn);
      chk({name, " err_o"}, err_o, exp_err);
      @(posedge clk); #1;
   endtask

   task automatic send_wait(input string name);
      bit ok = 1'b0;
      valid_i = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (ready_o) ok = 1'b1;
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      chk({name, " accepted"}, ok, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
      $fatal(1);
   end

   initial begin
      int          idx;
      logic [32:0] big;
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      set_fields(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      one_shot("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
      one_shot("sw", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423, 1'b0);
      one_shot("beq", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      one_shot("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0010_00EF, 1'b0);
      one_shot("bad op", 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 32'd77, 32'h0000_0013, 1'b1);
      chk("err_cnt after bad op", err_cnt_o, 16'd1);
`ifdef INSN_ENCODE_IMM_CHECK_EN
      one_shot("addi 4096", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h0000_0093, 1'b1);
      chk("err_cnt after addi 4096", err_cnt_o, 16'd2);
`else
      one_shot("addi 4096", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h0000_0093, 1'b0);
      chk("err_cnt after addi 4096", err_cnt_o, 16'd1);
`endif
      big = model_enc(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 32'h1234_5000);
      chk("model lui", big, {1'b0, 32'h1234_52B7});
      big = model_enc(7'h13, 5'd2, 5'd3, 5'd0, 3'd5, 7'h20, 5'd7, 32'd0);
      chk("model srai", big, {1'b0, 32'h4071_D113});

      // Backpressure: six bundles against a stalled consumer, four fit.
      ready_i = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         set_fields(ops[idx], 5'(idx + 1), 5'(idx), 5'(idx + 2), 3'd0, 7'd0, 5'd0,
                    32'(idx * 4), 32'h2000 + 32'(idx));
         valid_i = 1'b1;
         @(negedge clk);
         if (ready_o) idx++;
         @(posedge clk); #1;
      end
      chk("full accepted count", idx, 4);
      @(negedge clk);
      chk("full ready_o", ready_o, 0);
      ready_i = 1'b1;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         set_fields(ops[idx], 5'(idx + 1), 5'(idx), 5'(idx + 2), 3'd0, 7'd0, 5'd0,
                    32'(idx * 4), 32'h2000 + 32'(idx));
         valid_i = 1'b1;
         @(negedge clk);
         if (ready_o) idx++;
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      chk("drain accepted count", idx, 6);
      repeat (8) @(posedge clk);
      #1;

      for (int c = 0; c < 3000; c++) begin
         rand_fields();
         valid_i = ($urandom_range(0, 3) != 0);
         if ((c / 200) % 3 == 0) ready_i = ($urandom_range(0, 3) == 0);
         else                    ready_i = ($urandom_range(0, 1) == 1) || ((c / 200) % 3 == 2);
         @(posedge clk); #1;
      end
      valid_i = 1'b0; ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Reset with three entries buffered, one of them errored.
      ready_i = 1'b0;
      set_fields(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 5'd0, 32'd0, 32'h3000);
      send_wait("pre-rst bad");
      set_fields(7'h33, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 5'd0, 32'd0, 32'h3004);
      send_wait("pre-rst r");
      set_fields(7'h13, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 5'd0, 32'd9, 32'h3008);
      send_wait("pre-rst i");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre-rst valid_o", valid_o, 1);
      chk("pre-rst err_cnt nonzero", err_cnt_o != 16'd0, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst valid_o", valid_o, 0);
      chk("async rst err_cnt_o", err_cnt_o, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      ready_i = 1'b1;
      one_shot("post-rst addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
      chk("post-rst err_cnt", err_cnt_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
